tx_sync_arbiter: RTL

TX_SYNC_ARBITER -- requirements
Module: tx_sync_arbiter

---
 rtl/tx_sync_pkg.sv | 20 ++
 rtl/tx_sync_arbiter_rr_pick.sv | 27 ++
 rtl/tx_sync_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/tx_sync_pkg.sv
// Shared definitions for the transmitter-sync arbiter: FSM encoding and default sizes.
package tx_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OFFER = 2'b01,
    ST_BUSY  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_DW      = 8;
  localparam int DEF_TIMEOUT = 255;

  // Next requester index after idx, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tx_sync_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of i_req at or above i_ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  int w_cand;

  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[w_cand[IW-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/tx_sync_arbiter.sv
// Round-robin arbiter feeding NREQ requesters into one push-synchronizer transmitter.
// Optional watchdog built when TX_SYNC_ARB_WATCHDOG_EN is defined.
module tx_sync_arbiter
  import tx_sync_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int IW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_v,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_done,
  input  logic              txe,
  input  logic              txreq,
  output logic              vi,
  output logic [DW-1:0]     data_out,
  output logic [IW-1:0]     gnt_id,
  output logic              busy,
  output logic              timeout_err,
  output state_t            dbg_state
);

  // Handshake: vi is held while OFFER; the transmitter takes the word by raising
  // txreq, and the transfer is complete once txreq falls again (sync ack returned).

  state_t          r_state;
  state_t          w_next_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_gnt_id;
  logic [DW-1:0]   r_data_out;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_any;
  logic            w_grant;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req (req_v),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_grant = (r_state == ST_IDLE) && txe && !txreq && w_pick_any;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant) w_next_state = ST_OFFER;
      ST_OFFER: if (txreq) w_next_state = ST_BUSY;
      ST_BUSY:  if (!txreq) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_gnt_id   <= '0;
      r_data_out <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_gnt_id   <= w_pick_idx;
        r_data_out <= req_data[w_pick_idx*DW +: DW];
      end
      if (r_state == ST_DONE) begin
        r_ptr <= IW'(wrap_inc(32'(r_gnt_id), NREQ));
      end
    end
  end

  always_comb begin
    req_done = '0;
    if (r_state == ST_DONE) req_done[r_gnt_id] = 1'b1;
  end

  assign vi        = (r_state == ST_OFFER);
  assign busy      = (r_state != ST_IDLE);
  assign data_out  = r_data_out;
  assign gnt_id    = r_gnt_id;
  assign dbg_state = r_state;

`ifdef TX_SYNC_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wd_cnt;
  logic          r_timeout_err;

  // Counter saturates at TIMEOUT; the flag is sticky and never aborts the transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_OFFER || r_state == ST_BUSY) begin
      if (r_wd_cnt != CW'(TIMEOUT)) r_wd_cnt <= r_wd_cnt + 1'b1;
      if (r_wd_cnt == CW'(TIMEOUT - 1)) r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
